pe_8x8_cluster: RTL and testbench
=================================

PE_8X8_CLUSTER -- requirements
Module: pe_8x8_cluster

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 Port: en  input  1  global enable; 0 = all state holds.
REQ-005 Port: activations  input  128  eight 16-bit lanes; lane i = bits [16i+15:16i] feeds west edge of row i.
REQ-006 Port: weights  input  128  eight 16-bit lanes; lane j feeds north edge of column j.
REQ-007 Port: done  input  8  bit i = end-of-stream flag for row i, travels east with activations.
REQ-008 Port: o_activations  output  128  lane i = activation leaving east edge of row i (PE(i,7)).
REQ-009 Port: o_weights  output  128  lane j = weight leaving south edge of column j (PE(7,j)).
REQ-010 Port: results  output  128  lane i = accumulator of PE(i,7).
REQ-011 Port: output_dones  output  8  bit i = done flag leaving east edge of row i.

Function
REQ-012 The array SHALL be 8 rows x 8 columns of identical PEs, PE(r,c); r=0 at north edge, c=0 at west edge.
REQ-013 Each PE SHALL hold registers a_reg(16), w_reg(16), d_reg(1), acc(16), stop(1).
REQ-014 PE inputs: a_in from PE(r,c-1).a_reg or activations lane r when c=0; w_in from PE(r-1,c).w_reg or weights lane c when r=0; d_in from PE(r,c-1).d_reg or done[r] when c=0.
REQ-015 On each clk edge with rst_n=1 and en=1, every PE SHALL do: a_reg<=a_in, w_reg<=w_in, d_reg<=d_in, stop<=stop|d_in.
REQ-016 In the same edge, if stop=0 and d_in=0, acc SHALL become (acc + a_in*w_in) mod 2^16; otherwise acc holds.
REQ-017 Multiply SHALL be unsigned 16x16 with the product truncated to its low 16 bits before the add; the sum wraps mod 2^16 without saturation.
REQ-018 Once stop=1 the PE accumulator SHALL be frozen until reset, regardless of later a_in/w_in/done values.
REQ-019 With en=0 and rst_n=1, all registers SHALL hold.
REQ-020 Pass-through latency SHALL be 1 cycle per PE: activations lane r and done[r] appear on o_activations lane r and output_dones[r] 8 cycles later; weights lane c appears on o_weights lane c 8 cycles later.
REQ-021 Operand alignment: row r operand k SHALL be presented at cycle r+k and column c operand k at cycle c+k; PE(r,c) then multiplies pair k at cycle r+c+k. Unused slots SHALL carry 0, contributing nothing.
REQ-022 results lane r SHALL equal PE(r,7).acc combinationally from the register; it is final once output_dones[r]=1.
REQ-023 All outputs SHALL be direct register outputs (no combinational path from inputs to outputs).

Reset
REQ-024 When rst_n=0 at a clk edge, every a_reg, w_reg, d_reg, acc and stop SHALL clear to 0, independent of en; reset takes priority over en.
REQ-025 After reset all outputs SHALL read 0: results, o_activations, o_weights = 128'h0; output_dones = 8'h00.
REQ-026 Reset asserted mid-operation SHALL discard all partial sums and in-flight flags on that edge.

Verification
REQ-027 Reset: drive random inputs, rst_n=0 for 2 edges -> all outputs 0.
REQ-028 Single row: row 0 activations 1,2,3,4 at cycles 0..3, column 7 weights 5,6,7,8 at cycles 7..10, all else 0, done[0]=1 from cycle 4 -> results lane 0 = 70 (0x0046), output_dones[0] rises at cycle 12.
REQ-029 Full skewed load: row r a=r+1 and column c w=c+1 for 4 slots each with skew, done[r] after slot 4 -> results lane r = 4*(r+1)*8 mod 2^16 (lane 7 = 256), output_dones[7] last at cycle 19.
REQ-030 Wrap: a=0xFFFF, w=0x0002 twice into PE(0,7) -> product 0xFFFE each, acc = 0xFFFC.
REQ-031 Freeze: after done[0] reaches PE(0,7), keep feeding nonzero data -> results lane 0 unchanged.
REQ-032 Enable stall: en=0 for 3 cycles mid-stream -> outputs hold, final results identical to unstalled run.

Source files
------------

// File: rtl/pe_8x8_cluster.sv
// 8x8 output-stationary systolic MAC array: activations flow east, weights flow south,
// each PE accumulates a 16-bit wrapping sum until its end-of-stream flag arrives.
module pe_8x8_cluster (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [127:0] activations,
    input  logic [127:0] weights,
    input  logic [7:0]   done,
    output logic [127:0] o_activations,
    output logic [127:0] o_weights,
    output logic [127:0] results,
    output logic [7:0]   output_dones
);
    localparam int N = 8;
    localparam int W = 16;

    logic [W-1:0] a_r    [N][N];
    logic [W-1:0] w_r    [N][N];
    logic         d_r    [N][N];
    logic [W-1:0] acc_r  [N][N];
    logic         stop_r [N][N];

    logic [W-1:0] a_in_s [N][N];
    logic [W-1:0] w_in_s [N][N];
    logic         d_in_s [N][N];

    // Unsigned 16x16 multiply, product truncated to 16 bits, added with wrap.
    function automatic logic [W-1:0] mac16(input logic [W-1:0] acc,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] w);
        logic [2*W-1:0] prod;
        prod = {16'h0000, a} * {16'h0000, w};
        return acc + prod[W-1:0];
    endfunction

    // Neighbour wiring: west/north edges take the array inputs.
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            if (c == 0) begin : g_west
                assign a_in_s[r][c] = activations[W*r +: W];
                assign d_in_s[r][c] = done[r];
            end else begin : g_inner_a
                assign a_in_s[r][c] = a_r[r][c-1];
                assign d_in_s[r][c] = d_r[r][c-1];
            end
            if (r == 0) begin : g_north
                assign w_in_s[r][c] = weights[W*c +: W];
            end else begin : g_inner_w
                assign w_in_s[r][c] = w_r[r-1][c];
            end
        end
        assign o_activations[W*r +: W] = a_r[r][N-1];
        assign results[W*r +: W]       = acc_r[r][N-1];
        assign output_dones[r]         = d_r[r][N-1];
        assign o_weights[W*r +: W]     = w_r[N-1][r];
    end

    // PE state update: reset beats enable; a PE freezes its sum once done has been seen.
    always_ff @(posedge clk) begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (!rst_n) begin
                    a_r[r][c]    <= '0;
                    w_r[r][c]    <= '0;
                    d_r[r][c]    <= 1'b0;
                    acc_r[r][c]  <= '0;
                    stop_r[r][c] <= 1'b0;
                end else if (en) begin
                    a_r[r][c]    <= a_in_s[r][c];
                    w_r[r][c]    <= w_in_s[r][c];
                    d_r[r][c]    <= d_in_s[r][c];
                    stop_r[r][c] <= stop_r[r][c] | d_in_s[r][c];
                    if (!stop_r[r][c] && !d_in_s[r][c]) begin
                        acc_r[r][c] <= mac16(acc_r[r][c], a_in_s[r][c], w_in_s[r][c]);
                    end else begin
                        acc_r[r][c] <= acc_r[r][c];
                    end
                end else begin
                    a_r[r][c]    <= a_r[r][c];
                    w_r[r][c]    <= w_r[r][c];
                    d_r[r][c]    <= d_r[r][c];
                    acc_r[r][c]  <= acc_r[r][c];
                    stop_r[r][c] <= stop_r[r][c];
                end
            end
        end
    end
endmodule

// File: tb/tb_pe_8x8_cluster.sv
// Directed testbench for pe_8x8_cluster with hand-computed expectations.
module tb_pe_8x8_cluster;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [127:0] activations;
    logic [127:0] weights;
    logic [7:0]   done;
    logic [127:0] o_activations;
    logic [127:0] o_weights;
    logic [127:0] results;
    logic [7:0]   output_dones;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] exp_full;
    logic [127:0] snap_act, snap_w, snap_res;
    logic [7:0]   snap_done;

    pe_8x8_cluster dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .activations(activations), .weights(weights), .done(done),
        .o_activations(o_activations), .o_weights(o_weights),
        .results(results), .output_dones(output_dones)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b1;
        activations = '0; weights = '0; done = 8'h00;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    // Skewed load: row/column i operand k (value i+1) at cycle i+k, done[i] from cycle i+4.
    task automatic drive_full(input int t);
        activations = '0; weights = '0; done = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (t - i >= 0 && t - i < 4) begin
                activations[16*i +: 16] = 16'(i + 1);
                weights[16*i +: 16]     = 16'(i + 1);
            end
            if (t >= i + 4) done[i] = 1'b1;
        end
    endtask

    initial begin
        for (int r = 0; r < 8; r++) exp_full[16*r +: 16] = 16'(32 * (r + 1));

        // Reset: fill with random data, then reset with en low.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            activations = {$urandom, $urandom, $urandom, $urandom};
            weights     = {$urandom, $urandom, $urandom, $urandom};
            done        = 8'($urandom);
            tick();
        end
        rst_n = 1'b0; en = 1'b0;
        tick(); tick();
        check_eq("rst_results", results, 128'h0);
        check_eq("rst_o_act", o_activations, 128'h0);
        check_eq("rst_o_w", o_weights, 128'h0);
        check_eq("rst_dones", {120'h0, output_dones}, 128'h0);

        // Single row: 1..4 x 5..8 into PE(0,7).
        do_reset();
        for (int t = 0; t <= 14; t++) begin
            activations = '0; weights = '0;
            if (t < 4) activations[15:0] = 16'(t + 1);
            if (t >= 7 && t <= 10) weights[127:112] = 16'(t - 2);
            done = (t >= 4) ? 8'h01 : 8'h00;
            tick();
            if (t == 7)  check_eq("row_o_act_lat8", o_activations, 128'h1);
            if (t == 9)  check_eq("row_partial", results, 128'd38);
            if (t == 10) check_eq("row_done_early", {120'h0, output_dones}, 128'h0);
            if (t == 11) begin
                check_eq("row_done_rise", {120'h0, output_dones}, 128'h01);
                check_eq("row_result", results, 128'd70);
            end
            if (t == 14) check_eq("row_o_w_lat8", o_weights, {16'd5, 112'h0});
        end

        // Freeze: done dropped, nonzero data keeps flowing.
        done = 8'h00;
        activations = '0; weights = '0;
        activations[15:0] = 16'h0009;
        weights[127:112]  = 16'h0009;
        for (int k = 0; k < 12; k++) tick();
        check_eq("freeze_result", results, 128'd70);

        // Wrap: 0xFFFF*2 twice.
        do_reset();
        for (int t = 0; t <= 8; t++) begin
            activations = '0; weights = '0; done = 8'h00;
            if (t < 2) activations[15:0] = 16'hFFFF;
            if (t == 7 || t == 8) weights[127:112] = 16'h0002;
            tick();
            if (t == 7) check_eq("wrap_first", results, 128'hFFFE);
            if (t == 8) check_eq("wrap_second", results, 128'hFFFC);
        end

        // Full skewed load.
        do_reset();
        for (int t = 0; t <= 18; t++) begin
            drive_full(t);
            tick();
            if (t == 7) begin
                check_eq("full_o_act_c8", o_activations, 128'h1);
                check_eq("full_o_w_c8", o_weights, 128'h1);
            end
            if (t == 10) check_eq("full_o_act_c11", o_activations,
                                  128'h0000_0000_0000_0000_0004_0003_0002_0001);
            if (t == 17) check_eq("full_dones_c18", {120'h0, output_dones}, 128'h7F);
            if (t == 18) begin
                check_eq("full_dones_c19", {120'h0, output_dones}, 128'hFF);
                check_eq("full_results", results, exp_full);
            end
        end

        // Enable stall of 3 cycles mid-stream with garbage inputs.
        do_reset();
        for (int t = 0; t <= 18; t++) begin
            drive_full(t);
            en = 1'b1;
            tick();
            if (t == 7) begin
                snap_act = o_activations; snap_w = o_weights;
                snap_res = results; snap_done = output_dones;
                en = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    activations = {$urandom, $urandom, $urandom, $urandom};
                    weights     = {$urandom, $urandom, $urandom, $urandom};
                    done        = 8'hFF;
                    tick();
                end
                check_eq("stall_o_act", o_activations, snap_act);
                check_eq("stall_o_w", o_weights, snap_w);
                check_eq("stall_results", results, snap_res);
                check_eq("stall_dones", {120'h0, output_dones}, {120'h0, snap_done});
            end
        end
        check_eq("stall_final_results", results, exp_full);
        check_eq("stall_final_dones", {120'h0, output_dones}, 128'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
